// File: rtl/stream_arb_pkg.sv
// Shared arbitration types and the round-robin pick helper used by stream schedulers.
package stream_arb_pkg;

  typedef enum logic [1:0] {ARB_IDLE, ARB_PASS, ARB_FLUSH} arb_state_t;

  localparam int RR_MAX_PORTS = 16;
  localparam int RR_IDX_W     = 4;

  // First requester strictly after ptr, wrapping at n; returns ptr when nobody requests.
  function automatic logic [RR_IDX_W-1:0] rr_pick(input logic [RR_MAX_PORTS-1:0] req,
                                                  input logic [RR_IDX_W-1:0] ptr,
                                                  input int n);
    logic [RR_IDX_W-1:0] pick;
    logic found;
    int idx;
    pick  = ptr;
    found = 1'b0;
    for (int i = 1; i <= RR_MAX_PORTS; i++) begin
      idx = (int'(ptr) + i) % n;
      if (!found && (i <= n) && req[idx[RR_IDX_W-1:0]]) begin
        pick  = idx[RR_IDX_W-1:0];
        found = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/stream_out_reg.sv
// Single-entry registered AXIS stage; accepts a new word whenever empty or draining.
module stream_out_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready
);

  assign in_ready = !out_valid || out_ready;

  always_ff @(posedge clk) begin
    if (!rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (in_ready) begin
      out_valid <= in_valid;
      if (in_valid) out_data <= in_data;
    end
  end

endmodule

// File: rtl/stream_pkt_arbiter.sv
// Packet-granular round-robin arbiter feeding one fifo write port, with length truncation.
module stream_pkt_arbiter
  import stream_arb_pkg::*;
#(
  parameter int  NUM_PORTS     = 4,
  parameter int  DATA_WIDTH    = 36,
  parameter int  HDR_WIDTH     = 36,
  parameter int  MAX_PKT_BEATS = 4,
  localparam int SRC_W         = $clog2(NUM_PORTS)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0] s_data,
  input  logic [NUM_PORTS-1:0]            s_last,
  input  logic [NUM_PORTS*HDR_WIDTH-1:0]  s_header,
  input  logic [NUM_PORTS-1:0]            s_drop,
  input  logic [NUM_PORTS-1:0]            s_valid,
  output logic [NUM_PORTS-1:0]            s_ready,
  output logic [DATA_WIDTH-1:0]           m_data,
  output logic                            m_last,
  output logic [HDR_WIDTH-1:0]            m_header,
  output logic                            m_drop,
  output logic                            m_valid,
  input  logic                            m_ready,
  output logic [SRC_W-1:0]                m_src,
  output logic                            err_len
);

  localparam int PAY_W = DATA_WIDTH + HDR_WIDTH + SRC_W + 2;
  localparam int CNT_W = 16;

  arb_state_t             state;
  logic [SRC_W-1:0]       grant;
  logic [SRC_W-1:0]       rr_ptr;
  logic [SRC_W-1:0]       pick;
  logic [CNT_W-1:0]       beat_cnt;
  logic                   out_in_ready;
  logic                   accept;
  logic                   truncate;
  logic                   sel_valid;
  logic                   sel_last;
  logic                   sel_drop;
  logic [DATA_WIDTH-1:0]  sel_data;
  logic [HDR_WIDTH-1:0]   sel_header;
  logic [PAY_W-1:0]       pay_in;
  logic [PAY_W-1:0]       pay_out;

  assign pick = SRC_W'(rr_pick(RR_MAX_PORTS'(s_valid), RR_IDX_W'(rr_ptr), NUM_PORTS));

  assign sel_valid  = s_valid[grant];
  assign sel_last   = s_last[grant];
  assign sel_drop   = s_drop[grant];
  assign sel_data   = s_data[int'(grant)*DATA_WIDTH +: DATA_WIDTH];
  assign sel_header = s_header[int'(grant)*HDR_WIDTH +: HDR_WIDTH];

  assign accept   = (state == ARB_PASS) && sel_valid && out_in_ready;
  // The beat that reaches the limit without last becomes a forced, dropped end of packet.
  assign truncate = (MAX_PKT_BEATS > 0) && !sel_last &&
                    ((beat_cnt + 1'b1) == CNT_W'(MAX_PKT_BEATS));

  always_comb begin
    s_ready = '0;
    case (state)
      ARB_PASS:  s_ready[grant] = out_in_ready;
      ARB_FLUSH: s_ready[grant] = 1'b1;
      default:   s_ready = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= ARB_IDLE;
      grant    <= '0;
      rr_ptr   <= SRC_W'(NUM_PORTS - 1);
      beat_cnt <= '0;
      err_len  <= 1'b0;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (|s_valid) begin
            grant    <= pick;
            rr_ptr   <= pick;
            beat_cnt <= '0;
            state    <= ARB_PASS;
          end
        end
        ARB_PASS: begin
          if (accept) begin
            beat_cnt <= beat_cnt + 1'b1;
            if (sel_last) begin
              state <= ARB_IDLE;
            end else if (truncate) begin
              err_len <= 1'b1;
              state   <= ARB_FLUSH;
            end
          end
        end
        ARB_FLUSH: begin
          if (sel_valid && sel_last) state <= ARB_IDLE;
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

  assign pay_in = {grant, (sel_last ? sel_drop : truncate), (sel_last | truncate),
                   sel_header, sel_data};

  stream_out_reg #(.WIDTH(PAY_W)) u_out (
    .clk       (clk),
    .rst       (rst),
    .in_data   (pay_in),
    .in_valid  (accept),
    .in_ready  (out_in_ready),
    .out_data  (pay_out),
    .out_valid (m_valid),
    .out_ready (m_ready)
  );

  assign {m_src, m_drop, m_last, m_header, m_data} = pay_out;

endmodule

// File: tb/tb_stream_pkt_arbiter.sv
// Self-checking bench: cycle table for single-port timing, packet-level model for multi-port traffic.
module tb_stream_pkt_arbiter;

  localparam int NP   = 4;
  localparam int DW   = 36;
  localparam int HW   = 36;
  localparam int MAXB = 4;
  localparam int SW   = 2;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [NP*DW-1:0] s_data;
  logic [NP-1:0]    s_last;
  logic [NP*HW-1:0] s_header;
  logic [NP-1:0]    s_drop;
  logic [NP-1:0]    s_valid;
  logic [NP-1:0]    s_ready;
  logic [DW-1:0]    m_data;
  logic             m_last;
  logic [HW-1:0]    m_header;
  logic             m_drop;
  logic             m_valid;
  logic             m_ready;
  logic [SW-1:0]    m_src;
  logic             err_len;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  stream_pkt_arbiter #(
    .NUM_PORTS(NP), .DATA_WIDTH(DW), .HDR_WIDTH(HW), .MAX_PKT_BEATS(MAXB)
  ) dut (
    .clk(clk), .rst(rst), .s_data(s_data), .s_last(s_last), .s_header(s_header),
    .s_drop(s_drop), .s_valid(s_valid), .s_ready(s_ready), .m_data(m_data),
    .m_last(m_last), .m_header(m_header), .m_drop(m_drop), .m_valid(m_valid),
    .m_ready(m_ready), .m_src(m_src), .err_len(err_len)
  );

  typedef struct {
    logic          v;
    logic          last;
    logic [DW-1:0] d;
    logic          mr;
    logic          exp_sr;
    logic          exp_mv;
    logic [DW-1:0] exp_md;
    logic          exp_ml;
  } vec_t;

  typedef struct {
    int            port;
    int            len;
    logic          drop;
    logic [HW-1:0] hdr;
    logic [31:0]   base;
  } pkt_t;

  typedef struct {
    logic [DW-1:0] d;
    logic [HW-1:0] h;
    logic          last;
    logic          drop;
    logic [SW-1:0] src;
  } beat_t;

  vec_t  vecs[15];
  pkt_t  pkts[$];
  beat_t exp_q[$];
  beat_t obs_q[$];
  logic  exp_err;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  task automatic clearInputs();
    s_data   = '0;
    s_last   = '0;
    s_header = '0;
    s_drop   = '0;
    s_valid  = '0;
  endtask

  task automatic setVec(input int i, input logic v, input logic last, input logic [DW-1:0] d,
                        input logic mr, input logic sr, input logic mv, input logic [DW-1:0] md,
                        input logic ml);
    vecs[i] = '{v, last, d, mr, sr, mv, md, ml};
  endtask

  task automatic applyStimulus(input vec_t r);
    @(negedge clk);
    clearInputs();
    s_valid[0]      = r.v;
    s_last[0]       = r.last;
    s_data[DW-1:0]  = r.d;
    m_ready         = r.mr;
    #1;
  endtask

  function automatic logic [DW-1:0] beatData(input pkt_t p, input int b);
    return {4'(b), p.base};
  endfunction

  function automatic int nextPkt(input int port, input int after);
    for (int i = after + 1; i < pkts.size(); i++)
      if (pkts[i].port == port) return i;
    return -1;
  endfunction

  // Packet-level reference: rotate over ports with pending packets, emit each packet whole.
  task automatic buildExpected();
    int    nxt[NP];
    int    ptr;
    int    q;
    int    n;
    int    idx;
    bit    any;
    beat_t b;
    exp_q.delete();
    exp_err = 1'b0;
    ptr = NP - 1;
    for (int p = 0; p < NP; p++) nxt[p] = nextPkt(p, -1);
    forever begin
      any = 0;
      q   = 0;
      for (int k = 1; k <= NP; k++) begin
        if (!any && nxt[(ptr + k) % NP] >= 0) begin
          q   = (ptr + k) % NP;
          any = 1;
        end
      end
      if (!any) break;
      idx = nxt[q];
      n   = (MAXB > 0 && pkts[idx].len > MAXB) ? MAXB : pkts[idx].len;
      if (n != pkts[idx].len) exp_err = 1'b1;
      for (int i = 0; i < n; i++) begin
        b.d    = beatData(pkts[idx], i);
        b.h    = pkts[idx].hdr;
        b.src  = SW'(q);
        b.last = (i == n - 1);
        b.drop = b.last ? ((n != pkts[idx].len) ? 1'b1 : pkts[idx].drop) : 1'b0;
        exp_q.push_back(b);
      end
      nxt[q] = nextPkt(q, idx);
      ptr    = q;
    end
  endtask

  task automatic runPackets(input string tag, input bit rnd_ready, input bit bubbles);
    int          cur[NP];
    int          beat[NP];
    logic [NP-1:0] fire;
    bit          stalled;
    bit          finished;
    bit          all_done;
    beat_t       held;
    beat_t       now_b;
    clearInputs();
    m_ready = 1'b0;
    rst     = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    buildExpected();
    obs_q.delete();
    for (int p = 0; p < NP; p++) begin
      cur[p]  = nextPkt(p, -1);
      beat[p] = 0;
    end
    fire     = '0;
    stalled  = 0;
    finished = 0;
    held     = '{'0, '0, 1'b0, 1'b0, '0};
    for (int cyc = 0; cyc < 5000 && !finished; cyc++) begin
      @(negedge clk);
      for (int p = 0; p < NP; p++) begin
        if (fire[p]) begin
          beat[p]++;
          if (beat[p] == pkts[cur[p]].len) begin
            cur[p]  = nextPkt(p, cur[p]);
            beat[p] = 0;
          end
        end
      end
      for (int p = 0; p < NP; p++) begin
        if (cur[p] < 0) begin
          s_valid[p] = 1'b0;
        end else if (fire[p] || !s_valid[p]) begin
          s_valid[p]            = (beat[p] == 0 || !bubbles) ? 1'b1 : ($urandom_range(0, 2) != 0);
          s_data[p*DW +: DW]    = beatData(pkts[cur[p]], beat[p]);
          s_header[p*HW +: HW]  = pkts[cur[p]].hdr;
          s_last[p]             = (beat[p] == pkts[cur[p]].len - 1);
          s_drop[p]             = pkts[cur[p]].drop;
        end
      end
      m_ready = rnd_ready ? ($urandom_range(0, 2) != 0) : 1'b1;
      #1;
      fire  = s_valid & s_ready;
      now_b = '{m_data, m_header, m_last, m_drop, m_src};
      checkOutput({tag, "_sready_onehot"}, 64'($onehot0(s_ready)), 64'd1);
      if (stalled) begin
        checkOutput({tag, "_stall_valid"}, 64'(m_valid), 64'd1);
        checkOutput({tag, "_stall_data"}, 64'(m_data), 64'(held.d));
        checkOutput({tag, "_stall_last"}, 64'(m_last), 64'(held.last));
      end
      stalled = m_valid && !m_ready;
      held    = now_b;
      if (m_valid && m_ready) obs_q.push_back(now_b);
      all_done = 1;
      for (int p = 0; p < NP; p++) if (cur[p] >= 0) all_done = 0;
      if (all_done && !m_valid && obs_q.size() >= exp_q.size()) finished = 1;
    end
    if (!finished) checkOutput({tag, "_timeout"}, 64'd0, 64'd1);
    checkOutput({tag, "_beat_count"}, 64'(obs_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      checkOutput({tag, "_data"}, 64'(obs_q[i].d), 64'(exp_q[i].d));
      checkOutput({tag, "_hdr"}, 64'(obs_q[i].h), 64'(exp_q[i].h));
      checkOutput({tag, "_last"}, 64'(obs_q[i].last), 64'(exp_q[i].last));
      checkOutput({tag, "_drop"}, 64'(obs_q[i].drop), 64'(exp_q[i].drop));
      checkOutput({tag, "_src"}, 64'(obs_q[i].src), 64'(exp_q[i].src));
    end
    checkOutput({tag, "_err_len"}, 64'(err_len), 64'(exp_err));
    clearInputs();
  endtask

  task automatic addPkt(input int port, input int len, input logic drop);
    pkt_t pk;
    pk.port = port;
    pk.len  = len;
    pk.drop = drop;
    pk.hdr  = {4'(port), 32'($urandom)};
    pk.base = $urandom;
    pkts.push_back(pk);
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    clearInputs();
    m_ready = 1'b1;
    rst     = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checkOutput("reset_m_valid", 64'(m_valid), 64'd0);
    checkOutput("reset_s_ready", 64'(s_ready), 64'd0);
    checkOutput("reset_m_data", 64'(m_data), 64'd0);
    checkOutput("reset_m_src", 64'(m_src), 64'd0);
    checkOutput("reset_err_len", 64'(err_len), 64'd0);
    rst = 1'b1;

    // Port 0 alone: a 3-beat packet at full rate, then a 3-beat packet under backpressure.
    setVec(0,  1, 0, 36'hA_0000_00D0, 1, 0, 0, 36'h0,          0);
    setVec(1,  1, 0, 36'hA_0000_00D0, 1, 1, 0, 36'h0,          0);
    setVec(2,  1, 0, 36'hA_0000_00D1, 1, 1, 1, 36'hA_0000_00D0, 0);
    setVec(3,  1, 1, 36'hA_0000_00D2, 1, 1, 1, 36'hA_0000_00D1, 0);
    setVec(4,  0, 0, 36'h0,           1, 0, 1, 36'hA_0000_00D2, 1);
    setVec(5,  0, 0, 36'h0,           1, 0, 0, 36'h0,          0);
    setVec(6,  1, 0, 36'hB_0000_00E0, 1, 0, 0, 36'h0,          0);
    setVec(7,  1, 0, 36'hB_0000_00E0, 1, 1, 0, 36'h0,          0);
    setVec(8,  1, 0, 36'hB_0000_00E1, 0, 0, 1, 36'hB_0000_00E0, 0);
    setVec(9,  1, 0, 36'hB_0000_00E1, 0, 0, 1, 36'hB_0000_00E0, 0);
    setVec(10, 1, 0, 36'hB_0000_00E1, 1, 1, 1, 36'hB_0000_00E0, 0);
    setVec(11, 1, 1, 36'hB_0000_00E2, 0, 0, 1, 36'hB_0000_00E1, 0);
    setVec(12, 1, 1, 36'hB_0000_00E2, 1, 1, 1, 36'hB_0000_00E1, 0);
    setVec(13, 0, 0, 36'h0,           1, 0, 1, 36'hB_0000_00E2, 1);
    setVec(14, 0, 0, 36'h0,           1, 0, 0, 36'h0,          0);
    for (int i = 0; i < 15; i++) begin
      applyStimulus(vecs[i]);
      checkOutput($sformatf("tbl%0d_s_ready", i), 64'(s_ready), {60'd0, 3'd0, vecs[i].exp_sr});
      checkOutput($sformatf("tbl%0d_m_valid", i), 64'(m_valid), 64'(vecs[i].exp_mv));
      if (vecs[i].exp_mv) begin
        checkOutput($sformatf("tbl%0d_m_data", i), 64'(m_data), 64'(vecs[i].exp_md));
        checkOutput($sformatf("tbl%0d_m_last", i), 64'(m_last), 64'(vecs[i].exp_ml));
        checkOutput($sformatf("tbl%0d_m_drop", i), 64'(m_drop), 64'd0);
        checkOutput($sformatf("tbl%0d_m_src", i), 64'(m_src), 64'd0);
      end
    end

    // All four ports with two 2-beat packets each: strict rotation 0,1,2,3,0,1,2,3.
    pkts.delete();
    for (int r = 0; r < 2; r++)
      for (int p = 0; p < NP; p++) addPkt(p, 2, 1'b0);
    runPackets("rotate", 1'b0, 1'b0);
    for (int i = 0; i < obs_q.size(); i++)
      checkOutput("rotate_order", 64'(obs_q[i].src), 64'((i / 2) % NP));

    // Drop request on the last beat of a 2-beat packet.
    pkts.delete();
    addPkt(1, 2, 1'b1);
    addPkt(0, 2, 1'b0);
    runPackets("drop", 1'b1, 1'b0);

    // Over-length packet on port 2, exact-length packets on port 3.
    pkts.delete();
    addPkt(2, 6, 1'b0);
    addPkt(3, 4, 1'b0);
    addPkt(3, 4, 1'b1);
    runPackets("trunc", 1'b1, 1'b1);

    // Reset in the middle of a packet clears everything, including err_len and the rotation.
    @(negedge clk);
    s_valid[1]         = 1'b1;
    s_data[DW +: DW]   = 36'h1_1111_0000;
    m_ready            = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    checkOutput("midrst_pre_valid", 64'(m_valid), 64'd1);
    checkOutput("midrst_pre_err", 64'(err_len), 64'd1);
    rst                = 1'b0;
    s_valid            = 4'b1010;
    s_data[3*DW +: DW] = 36'h3_3333_0000;
    @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput("midrst_m_valid", 64'(m_valid), 64'd0);
    checkOutput("midrst_m_last", 64'(m_last), 64'd0);
    checkOutput("midrst_m_drop", 64'(m_drop), 64'd0);
    checkOutput("midrst_m_data", 64'(m_data), 64'd0);
    checkOutput("midrst_m_header", 64'(m_header), 64'd0);
    checkOutput("midrst_m_src", 64'(m_src), 64'd0);
    checkOutput("midrst_s_ready", 64'(s_ready), 64'd0);
    checkOutput("midrst_err_len", 64'(err_len), 64'd0);
    @(negedge clk);
    #1;
    checkOutput("midrst_regrant", 64'(s_ready), 64'b0010);
    clearInputs();

    // Randomized traffic with source bubbles and output backpressure.
    for (int run = 0; run < 2; run++) begin
      pkts.delete();
      for (int k = 0; k < 40; k++)
        addPkt($urandom_range(0, NP - 1), $urandom_range(1, 7), 1'($urandom_range(0, 1)));
      runPackets($sformatf("rand%0d", run), 1'b1, 1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
